// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM sequencing controller.
//   state_t    : controller phase (IDLE, ISSUE, WAIT, RESP)
//   port_idx_t : requester index (0 or 1)
//   MAX_LATENCY: largest supported RAM read latency
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef logic port_idx_t;

  localparam int unsigned MAX_LATENCY = 7;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with a registered priority pointer.
//   clk, reset : clock, synchronous active-high reset (pointer -> port 0)
//   valid[1:0] : per-port request
//   advance    : a grant is being taken this cycle; pointer moves past it
//   gnt        : granted port (combinational; meaningful only when |valid)
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       advance,
  output port_idx_t  gnt
);

  port_idx_t rr_ptr;

  // Tie goes to the pointer, otherwise the lone requester wins.
  always_comb begin
    gnt = rr_ptr;
    if (valid == 2'b01) begin
      gnt = 1'b0;
    end else if (valid == 2'b10) begin
      gnt = 1'b1;
    end
  end

  // Point at the other port after every grant so neither can be served twice in a row while the other waits.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (advance) begin
      rr_ptr <= ~gnt;
    end
  end

endmodule

// File: rtl/ram_arbiter_2p.sv
// Shares one single-port word RAM between two requesters. A granted request is
// latched, driven to the RAM for exactly one enabled cycle, the RAM read latency
// is waited out, and the (pre-write) read word is returned with a one-cycle
// completion pulse on the granted port.
//   clk, reset             : clock, synchronous active-high reset
//   req_valid/addr/strobe/wdata : per-port request, held until that port's resp_ok
//   resp_ok, resp_data     : per-port completion pulse and registered read data
//   ram_en/addr/strobe/wdata : RAM command (enable only during the issue cycle)
//   ram_rdata              : RAM read data, READ_LATENCY cycles after the enable
module ram_arbiter_2p
  import ram_arb_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH   = 10,
  parameter  int unsigned DATA_WIDTH   = 64,
  parameter  int unsigned BYTE_WIDTH   = 64,
  parameter  int unsigned READ_LATENCY = 0,
  localparam int unsigned SW           = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 req_valid,
  input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0][SW-1:0]         req_strobe,
  input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]                 resp_ok,
  output logic [1:0][DATA_WIDTH-1:0] resp_data,
  output logic                       ram_en,
  output logic [ADDR_WIDTH-1:0]      ram_addr,
  output logic [SW-1:0]              ram_strobe,
  output logic [DATA_WIDTH-1:0]      ram_wdata,
  input  logic [DATA_WIDTH-1:0]      ram_rdata
);

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [SW-1:0]         strobe_t;

  localparam logic [2:0] CNT_INIT = 3'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);

  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_byte_width
    $error("ram_arbiter_2p: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (READ_LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("ram_arbiter_2p: READ_LATENCY exceeds MAX_LATENCY");
  end

  state_t    state;
  port_idx_t gnt;
  port_idx_t lat_gnt;
  logic [2:0] cnt;
  logic      advance;

  word_t   sel_wdata;
  addr_t   sel_addr;
  strobe_t sel_strobe;

  assign advance    = (state == IDLE) && (|req_valid);
  assign sel_addr   = req_addr[gnt];
  assign sel_strobe = req_strobe[gnt];
  assign sel_wdata  = req_wdata[gnt];

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .valid   (req_valid),
    .advance (advance),
    .gnt     (gnt)
  );

  // Sequencer. ram_addr/ram_wdata double as the latched request copy: they are
  // loaded on grant and held until the next grant, which keeps the address
  // stable across the RAM read pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lat_gnt    <= 1'b0;
      cnt        <= '0;
      resp_ok    <= '0;
      resp_data  <= '0;
      ram_en     <= 1'b0;
      ram_addr   <= '0;
      ram_strobe <= '0;
      ram_wdata  <= '0;
    end else begin
      resp_ok    <= '0;
      ram_en     <= 1'b0;
      ram_strobe <= '0;
      case (state)
        IDLE: begin
          if (advance) begin
            lat_gnt    <= gnt;
            ram_en     <= 1'b1;
            ram_addr   <= sel_addr;
            ram_strobe <= sel_strobe;
            ram_wdata  <= sel_wdata;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (READ_LATENCY == 0) begin
            resp_data[lat_gnt] <= ram_rdata;
            resp_ok[lat_gnt]   <= 1'b1;
            state              <= RESP;
          end else begin
            cnt   <= CNT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            resp_data[lat_gnt] <= ram_rdata;
            resp_ok[lat_gnt]   <= 1'b1;
            state              <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Bench for ram_arbiter_2p: two instances (read latency 0 and 2, byte strobes)
// each driving a behavioural read-first RAM, checked against a word-level
// reference memory and a round-robin service-order model.
module tb_ram_arbiter_2p;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = 8;

  logic clk;
  logic reset;
  logic ram_init;

  logic [1:0]         req_valid  [2];
  logic [1:0][AW-1:0] req_addr   [2];
  logic [1:0][SW-1:0] req_strobe [2];
  logic [1:0][DW-1:0] req_wdata  [2];
  logic [1:0]         resp_ok    [2];
  logic [1:0][DW-1:0] resp_data  [2];
  logic               ram_en     [2];
  logic [AW-1:0]      ram_addr   [2];
  logic [SW-1:0]      ram_strobe [2];
  logic [DW-1:0]      ram_wdata  [2];
  logic [DW-1:0]      ram_rdata  [2];

  logic [DW-1:0] ram_mem  [2][1024];
  logic [DW-1:0] ram_pipe [2][8];

  logic [DW-1:0] ref_mem  [2][1024];
  logic [DW-1:0] ref_resp [2][2];
  int            last_gnt [2];

  int n_pass;
  int n_fail;
  int n_total;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    ram_arbiter_2p #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .BYTE_WIDTH   (8),
      .READ_LATENCY ((k == 0) ? 0 : 2)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid[k]),
      .req_addr   (req_addr[k]),
      .req_strobe (req_strobe[k]),
      .req_wdata  (req_wdata[k]),
      .resp_ok    (resp_ok[k]),
      .resp_data  (resp_data[k]),
      .ram_en     (ram_en[k]),
      .ram_addr   (ram_addr[k]),
      .ram_strobe (ram_strobe[k]),
      .ram_wdata  (ram_wdata[k]),
      .ram_rdata  (ram_rdata[k])
    );
  end

  always #5 clk = ~clk;

  // Read-first single-port RAMs: instance 0 asynchronous read, instance 1 two-stage read pipe.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ram_init) begin
        for (int i = 0; i < 1024; i++) ram_mem[k][i] <= '0;
        for (int i = 0; i < 8; i++) ram_pipe[k][i] <= '0;
      end else begin
        for (int i = 1; i < 8; i++) ram_pipe[k][i] <= ram_pipe[k][i-1];
        if (ram_en[k]) begin
          ram_pipe[k][0] <= ram_mem[k][ram_addr[k]];
          for (int b = 0; b < 8; b++)
            if (ram_strobe[k][b]) ram_mem[k][ram_addr[k]][8*b +: 8] <= ram_wdata[k][8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    ram_rdata[0] = ram_mem[0][ram_addr[0]];
    ram_rdata[1] = ram_pipe[1][1];
  end

  function automatic int lat(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [SW-1:0] s,
                                          input logic [DW-1:0] w);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  // Whoever is waiting gets served; on a tie, the port not served last.
  function automatic int next_port(input int k, input logic [1:0] pend);
    if (pend == 2'b11) return (last_gnt[k] == 0) ? 1 : 0;
    return pend[1] ? 1 : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int k, input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL i%0d.%s observed=%0h expected=%0h", k, tag, obs, exp);
    end
  endtask

  task automatic check_zero(input int k, input string tag);
    chk(k, {tag, "_resp_ok"}, 64'(resp_ok[k]), 64'd0);
    chk(k, {tag, "_resp_data0"}, resp_data[k][0], 64'd0);
    chk(k, {tag, "_resp_data1"}, resp_data[k][1], 64'd0);
    chk(k, {tag, "_ram_en"}, 64'(ram_en[k]), 64'd0);
    chk(k, {tag, "_ram_addr"}, 64'(ram_addr[k]), 64'd0);
    chk(k, {tag, "_ram_strobe"}, 64'(ram_strobe[k]), 64'd0);
    chk(k, {tag, "_ram_wdata"}, ram_wdata[k], 64'd0);
  endtask

  // Present requests on the ports in mask and follow them to completion.
  // keep=1 holds both requests valid for four back-to-back services.
  task automatic run_round(input int k, input logic [1:0] mask, input bit keep,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                           input logic [DW-1:0] w0, input logic [DW-1:0] w1);
    logic [AW-1:0] a [2];
    logic [SW-1:0] s [2];
    logic [DW-1:0] w [2];
    logic [1:0] pend;
    int p, done, ntx, cyc, en_cyc, prev_en, n_en;
    a[0] = a0; a[1] = a1; s[0] = s0; s[1] = s1; w[0] = w0; w[1] = w1;
    for (int q = 0; q < 2; q++) begin
      if (mask[q]) begin
        req_addr[k][q]   = a[q];
        req_strobe[k][q] = s[q];
        req_wdata[k][q]  = w[q];
      end
    end
    req_valid[k] = mask;
    ntx = keep ? 4 : $countones(mask);
    pend = mask; done = 0; cyc = 0; en_cyc = -1; prev_en = -1; n_en = 0;
    p = next_port(k, pend);
    while (done < ntx && cyc < 16 * ntx) begin
      step();
      cyc++;
      if (ram_en[k]) begin
        chk(k, "en_addr", 64'(ram_addr[k]), 64'(a[p]));
        chk(k, "en_strobe", 64'(ram_strobe[k]), 64'(s[p]));
        if (s[p] != '0) chk(k, "en_wdata", ram_wdata[k], w[p]);
        if (prev_en >= 0) chk(k, "en_spacing", 64'(cyc - prev_en), 64'(lat(k) + 3));
        prev_en = cyc;
        en_cyc = cyc;
        n_en++;
      end else begin
        chk(k, "strobe_idle", 64'(ram_strobe[k]), 64'd0);
      end
      if (resp_ok[k] != 2'b00) begin
        chk(k, "ok_port", 64'(resp_ok[k]), (p == 0) ? 64'd1 : 64'd2);
        chk(k, "en_to_ok", 64'(cyc - en_cyc), 64'(lat(k) + 1));
        if (done == 0) chk(k, "req_to_ok", 64'(cyc), 64'(lat(k) + 2));
        chk(k, "en_count", 64'(n_en), 64'd1);
        ref_resp[k][p] = ref_mem[k][a[p]];
        ref_mem[k][a[p]] = merge(ref_mem[k][a[p]], s[p], w[p]);
        chk(k, "rdata", resp_data[k][p], ref_resp[k][p]);
        chk(k, "other_hold", resp_data[k][1-p], ref_resp[k][1-p]);
        last_gnt[k] = p;
        done++;
        n_en = 0;
        if (!keep) begin
          pend[p] = 1'b0;
          req_valid[k][p] = 1'b0;
        end
        if (done < ntx) p = next_port(k, pend);
        else req_valid[k] = 2'b00;
      end
    end
    if (done < ntx) chk(k, "timeout", 64'(done), 64'(ntx));
    req_valid[k] = 2'b00;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    ram_init = 1'b1;
    n_pass = 0;
    n_fail = 0;
    n_total = 0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = '0;
      req_addr[k] = '0;
      req_strobe[k] = '0;
      req_wdata[k] = '0;
      last_gnt[k] = 1;
      ref_resp[k][0] = '0;
      ref_resp[k][1] = '0;
      for (int i = 0; i < 1024; i++) ref_mem[k][i] = '0;
    end
    repeat (3) step();
    reset = 1'b0;
    ram_init = 1'b0;
    for (int k = 0; k < 2; k++) check_zero(k, "reset");

    // Latency 0: full write then readback of addr 5 on port 0.
    run_round(0, 2'b01, 0, 10'd5, 10'd0, 8'hFF, 8'h00, 64'h1122334455667788, 64'h0);
    chk(0, "t1_old_word", resp_data[0][0], 64'h0);
    run_round(0, 2'b01, 0, 10'd5, 10'd0, 8'h00, 8'h00, 64'h0, 64'h0);
    chk(0, "t1_readback", resp_data[0][0], 64'h1122334455667788);

    // Latency 2: partial-strobe write from port 1 over an existing word.
    run_round(1, 2'b01, 0, 10'd5, 10'd0, 8'hFF, 8'h00, 64'h1122334455667788, 64'h0);
    run_round(1, 2'b10, 0, 10'd0, 10'd5, 8'h00, 8'h0F, 64'h0, 64'hAAAAAAAAAAAAAAAA);
    chk(1, "t2_write_old", resp_data[1][1], 64'h1122334455667788);
    run_round(1, 2'b10, 0, 10'd0, 10'd5, 8'h00, 8'h00, 64'h0, 64'h0);
    chk(1, "t2_merge", resp_data[1][1], 64'h11223344AAAAAAAA);

    // Request fields changed while waiting must not affect the transaction.
    req_addr[1][0] = 10'd5;
    req_strobe[1][0] = '0;
    req_valid[1] = 2'b01;
    step();
    chk(1, "t4_issue_en", 64'(ram_en[1]), 64'd1);
    chk(1, "t4_issue_addr", 64'(ram_addr[1]), 64'd5);
    req_addr[1][0] = 10'd9;
    step();
    chk(1, "t4_wait1_en", 64'(ram_en[1]), 64'd0);
    chk(1, "t4_wait1_addr", 64'(ram_addr[1]), 64'd5);
    step();
    chk(1, "t4_wait0_addr", 64'(ram_addr[1]), 64'd5);
    chk(1, "t4_wait0_ok", 64'(resp_ok[1]), 64'd0);
    step();
    chk(1, "t4_resp_ok", 64'(resp_ok[1]), 64'd1);
    chk(1, "t4_resp_data", resp_data[1][0], 64'h11223344AAAAAAAA);
    chk(1, "t4_resp_addr", 64'(ram_addr[1]), 64'd5);
    req_valid[1] = 2'b00;
    ref_resp[1][0] = ref_mem[1][5];
    last_gnt[1] = 0;
    step();

    // Reset during the wait of a write: no completion, write stays committed.
    req_addr[1][1] = 10'd7;
    req_strobe[1][1] = 8'hFF;
    req_wdata[1][1] = 64'hDEADBEEFCAFEF00D;
    req_valid[1] = 2'b10;
    step();
    chk(1, "t5_issue_en", 64'(ram_en[1]), 64'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_valid[1] = 2'b00;
    for (int k = 0; k < 2; k++) begin
      check_zero(k, "t5_after_reset");
      ref_resp[k][0] = '0;
      ref_resp[k][1] = '0;
      last_gnt[k] = 1;
    end
    chk(1, "t5_committed", ram_mem[1][7], 64'hDEADBEEFCAFEF00D);
    ref_mem[1][7] = 64'hDEADBEEFCAFEF00D;
    step();
    chk(1, "t5_no_ok", 64'(resp_ok[1]), 64'd0);

    // Tie after reset goes to port 0; then a continuous two-port read stream alternates.
    for (int k = 0; k < 2; k++) begin
      run_round(k, 2'b11, 0, 10'd1, 10'd2, 8'hFF, 8'hFF, 64'h0101010101010101, 64'h0202020202020202);
      chk(k, "tie_last_port", 64'(last_gnt[k]), 64'd1);
      run_round(k, 2'b11, 1, 10'd1, 10'd2, 8'h00, 8'h00, 64'h0, 64'h0);
      chk(k, "stream_d0", resp_data[k][0], 64'h0101010101010101);
      chk(k, "stream_d1", resp_data[k][1], 64'h0202020202020202);
    end

    // A plain read leaves the RAM untouched.
    for (int k = 0; k < 2; k++) begin
      run_round(k, 2'b01, 0, 10'd5, 10'd0, 8'h00, 8'h00, 64'hFFFFFFFFFFFFFFFF, 64'h0);
      chk(k, "t6_unchanged", ram_mem[k][5], ref_mem[k][5]);
    end

    // Randomised traffic over a small address window.
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 40; r++) begin
        logic [1:0] m;
        logic [AW-1:0] ra0, ra1;
        logic [SW-1:0] rs0, rs1;
        logic [DW-1:0] rw0, rw1;
        m   = 2'($urandom_range(1, 3));
        ra0 = AW'($urandom_range(0, 15));
        ra1 = AW'($urandom_range(0, 15));
        rs0 = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
        rs1 = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
        rw0 = {$urandom, $urandom};
        rw1 = {$urandom, $urandom};
        run_round(k, m, 0, ra0, ra1, rs0, rs1, rw0, rw1);
      end
      for (int i = 0; i < 16; i++) chk(k, "final_mem", ram_mem[k][i], ref_mem[k][i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
